// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-RAM loader: FSM encoding, word geometry
// and the big-endian byte-packing helper.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  // Earlier bytes migrate toward the MSB, so the first byte of a word ends up in [31:24].
  function automatic logic [WORD_W-1:0] pack_byte(input logic [WORD_W-1:0] buf_v,
                                                  input logic [7:0] b);
    return {buf_v[WORD_W-9:0], b};
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Byte-to-word packer: counts accepted bytes and shifts them into a 32-bit buffer,
// presenting the completed word combinationally alongside the 4th byte's transfer.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic              byte_ready,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [BYTE_CNT_W-1:0] cnt_reg;
  logic [WORD_W-1:0]     buf_reg;
  logic                  transfer;

  assign transfer   = byte_valid & byte_ready;
  assign word       = pack_byte(buf_reg, byte_data);
  assign word_valid = transfer && (cnt_reg == BYTE_CNT_W'(BYTES_PER_WORD - 1));

  // The counter wraps naturally from 3 back to 0 on the word-completing byte.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      cnt_reg <= '0;
      buf_reg <= '0;
    end else if (transfer) begin
      cnt_reg <= cnt_reg + BYTE_CNT_W'(1);
      buf_reg <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-RAM loader: packs a serial byte stream into big-endian words, writes them to
// consecutive word addresses and holds the CPU pipeline until a load completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_words,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           checksum
);

  localparam logic [ADDR_WIDTH+1:0] MAX_WORDS =
    (ADDR_WIDTH+2)'((1 << ADDR_WIDTH) - BASE_ADDR);

  loader_state_t state_reg, state_next;

  logic [ADDR_WIDTH:0]   words_reg;
  logic [ADDR_WIDTH:0]   word_cnt_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]           wdata_reg;
  logic [31:0]           checksum_reg;
  logic                  err_reg;

  logic                  start_accept;
  logic                  start_reject;
  logic                  too_big;
  logic                  last_word;
  logic [WORD_W-1:0]     packed_word;
  logic                  word_valid;

  assign too_big   = {1'b0, load_words} > MAX_WORDS;
  assign last_word = (word_cnt_reg + (ADDR_WIDTH+1)'(1)) == words_reg;

  imem_loader_byte_packer u_packer (
    .clk        (CLK),
    .srst       (RESET),
    .clear      (start_accept),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .word       (packed_word),
    .word_valid (word_valid)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A rejected load_start from DONE falls back to IDLE so done never outlives a new request.
  always_comb begin
    state_next   = state_reg;
    start_accept = 1'b0;
    start_reject = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (load_start) begin
          if (too_big) begin
            start_reject = 1'b1;
            state_next   = ST_IDLE;
          end else begin
            start_accept = 1'b1;
            state_next   = (load_words == '0) ? ST_DONE : ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (word_valid) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_next = last_word ? ST_DONE : ST_RECV;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      words_reg    <= '0;
      word_cnt_reg <= '0;
      addr_reg     <= ADDR_WIDTH'(BASE_ADDR);
      wdata_reg    <= '0;
      checksum_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (start_reject) begin
        err_reg <= 1'b1;
      end
      if (start_accept) begin
        err_reg      <= 1'b0;
        checksum_reg <= '0;
        word_cnt_reg <= '0;
        words_reg    <= load_words;
      end
      // Address and data are latched with the completing byte so they are stable for WRITE.
      if (word_valid) begin
        addr_reg  <= ADDR_WIDTH'(BASE_ADDR) + word_cnt_reg[ADDR_WIDTH-1:0];
        wdata_reg <= packed_word;
      end
      if (state_reg == ST_WRITE) begin
        checksum_reg <= checksum_reg ^ wdata_reg;
        word_cnt_reg <= word_cnt_reg + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  assign byte_ready = (state_reg == ST_RECV);
  assign imem_we    = (state_reg == ST_WRITE);
  assign cpu_hold   = (state_reg != ST_DONE);
  assign done       = (state_reg == ST_DONE);
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign checksum   = checksum_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares them whenever imem_we is seen.
module tb_imem_loader;

  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          load_start = 1'b0;
  logic [AW:0]   load_words = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;
  logic [31:0]   checksum;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .load_start (load_start),
    .load_words (load_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .checksum   (checksum)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] ref_csum = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge CLK) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(mon_e.addr));
        check("write_data", imem_wdata, mon_e.data);
        check("ready_low_in_write", 32'(byte_ready), 32'd0);
        $display("write addr=%0d data=%h", imem_addr, imem_wdata);
      end
    end
  end

  task automatic pulse_start(input int n);
    load_start = 1'b1;
    load_words = (AW+1)'(n);
    @(negedge CLK);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    int   budget;
    rdy    = 1'b0;
    budget = 0;
    for (int g = 0; g < gap; g++) @(negedge CLK);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!rdy && budget < 50) begin
      rdy = byte_ready;
      @(negedge CLK);
      budget++;
    end
    byte_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got no byte_ready expected acceptance of %h", b);
    end
  endtask

  // Word index idx of the current load; bytes go out most-significant first.
  task automatic send_word(input int idx, input int max_gap);
    logic [7:0]  b [4];
    logic [31:0] w;
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
    w = 32'(b[0]) * 32'd16777216 + 32'(b[1]) * 32'd65536 + 32'(b[2]) * 32'd256 + 32'(b[3]);
    exp_q.push_back('{addr: AW'(idx), data: w});
    ref_csum = ref_csum ^ w;
    for (int i = 0; i < 4; i++) send_byte(b[i], $urandom_range(0, max_gap));
    check("write_latency", 32'(imem_we), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=%b expected 1", done);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_imem_we"},    32'(imem_we),    32'd0);
    check({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
    check({tag, "_imem_wdata"}, imem_wdata,      32'd0);
    check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_err"},        32'(err),        32'd0);
    check({tag, "_checksum"},   checksum,        32'd0);
  endtask

  initial begin
    logic [7:0] first [4];
    first[0] = 8'h8C; first[1] = 8'h01; first[2] = 8'h00; first[3] = 8'h04;

    // 1. reset
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    check_reset_state("reset");

    // 2. single fixed word, back-to-back bytes
    pulse_start(1);
    ref_csum = '0;
    exp_q.push_back('{addr: AW'(0), data: 32'h8C010004});
    for (int i = 0; i < 4; i++) send_byte(first[i], 0);
    check("single_latency", 32'(imem_we), 32'd1);
    @(negedge CLK);
    check("single_done", 32'(done), 32'd1);
    check("single_hold", 32'(cpu_hold), 32'd0);
    check("single_checksum", checksum, 32'h8C010004);

    // 3. three random words with idle gaps
    pulse_start(3);
    check("reload_done_drop", 32'(done), 32'd0);
    check("reload_hold_rise", 32'(cpu_hold), 32'd1);
    ref_csum = '0;
    for (int i = 0; i < 3; i++) send_word(i, 3);
    wait_done(20);
    check("three_checksum", checksum, ref_csum);
    check("three_hold", 32'(cpu_hold), 32'd0);

    // 4a. zero-length load
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    pulse_start(0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_checksum", checksum, 32'd0);
    check("zero_err", 32'(err), 32'd0);

    // 4b. oversize load rejected, bytes ignored
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    pulse_start((1 << AW) + 1);
    check("big_err", 32'(err), 32'd1);
    check("big_idle_hold", 32'(cpu_hold), 32'd1);
    check("big_idle_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (5) @(negedge CLK);
    byte_valid = 1'b0;
    check("big_ready_still_low", 32'(byte_ready), 32'd0);
    check("big_done", 32'(done), 32'd0);

    // 4c. full-RAM load up to the top address
    pulse_start(1 << AW);
    check("full_err_clear", 32'(err), 32'd0);
    ref_csum = '0;
    for (int i = 0; i < (1 << AW); i++) send_word(i, 0);
    wait_done(10);
    check("full_last_addr", 32'(imem_addr), 32'((1 << AW) - 1));
    check("full_checksum", checksum, ref_csum);

    // 5. reset mid-word during a 4-word load
    pulse_start(4);
    ref_csum = '0;
    send_word(0, 1);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_state("midreset");
    pulse_start(1);
    ref_csum = '0;
    send_word(0, 2);
    wait_done(10);
    check("midreset_checksum", checksum, ref_csum);

    // 6. load_start during RECV ignored; in DONE it starts a reload
    pulse_start(2);
    ref_csum = '0;
    send_word(0, 1);
    send_byte(8'h11, 0);
    pulse_start(5);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    exp_q.push_back('{addr: AW'(1), data: 32'h11223344});
    ref_csum = ref_csum ^ 32'h11223344;
    wait_done(10);
    check("recv_ignore_checksum", checksum, ref_csum);
    pulse_start(1);
    check("done_reload_done", 32'(done), 32'd0);
    check("done_reload_ready", 32'(byte_ready), 32'd1);
    ref_csum = '0;
    send_word(0, 3);
    wait_done(10);
    check("done_reload_checksum", checksum, ref_csum);

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
